// File: rtl/hazard_pkg.sv
// Shared constants for the load-use hazard scoreboard.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W_DEFAULT = 5;
  localparam int unsigned CNT_W              = 3;
  localparam int unsigned LOAD_LAT_MIN       = 1;
  localparam int unsigned LOAD_LAT_MAX       = 7;

  // Force a load latency into the range the countdown can represent.
  function automatic logic [CNT_W-1:0] clamp_lat(input int unsigned lat);
    if (lat < LOAD_LAT_MIN) begin
      return CNT_W'(LOAD_LAT_MIN);
    end else if (lat > LOAD_LAT_MAX) begin
      return CNT_W'(LOAD_LAT_MAX);
    end else begin
      return CNT_W'(lat);
    end
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: busy flag plus countdown to load-result forwardability.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clear,
  input  logic hold,
  output logic busy
);

  localparam logic [CNT_W-1:0] LatCnt = clamp_lat(LOAD_LAT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // Next state: clear beats set, set beats countdown expiry.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (clear) begin
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (set) begin
      cnt_d  = LatCnt;
      busy_d = 1'b1;
    end else if (!hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  // Entry state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard scoreboard: flags ID-stage sources that read a register
// whose load result is not yet forwardable, and requests a stall.
// Optional feature macro: HAZARD_PERF_CNT_EN adds a saturating stall-cycle counter.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          issue_valid,
  input  logic                          issue_mem_read,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]            src_used,
  input  logic                          mem_wait,
  input  logic                          flush,
  output logic [NUM_SRC-1:0]            hazard_vec,
  output logic                          stall
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                   stall_count
`endif
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

  logic [NumRegs-1:0]    busy_vec;
  logic                  load_issue;
  logic [REG_ADDR_W-1:0] src_sel;

  // A stalled cycle issues a bubble, and flush kills the advancing load.
  assign load_issue = issue_valid & issue_mem_read & ~stall & ~flush;

  for (genvar r = 0; r < NumRegs; r++) begin : g_entry
    logic set_r;
    // x0 is hardwired zero, so a load to it never creates a dependency.
    assign set_r = load_issue && (issue_rd == REG_ADDR_W'(r)) && (r != 0);

    hazard_sb_entry #(
      .LOAD_LAT (LOAD_LAT)
    ) u_entry (
      .clk   (CLK),
      .rst   (RESET),
      .set   (set_r),
      .clear (flush),
      .hold  (mem_wait),
      .busy  (busy_vec[r])
    );
  end

  // Per-source hazard lookup, straight from registered busy state.
  always_comb begin
    hazard_vec = '0;
    src_sel    = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src_sel       = src_addr[i*REG_ADDR_W +: REG_ADDR_W];
      hazard_vec[i] = src_used[i] && (src_sel != '0) && busy_vec[src_sel];
    end
  end

  assign stall = |hazard_vec;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count_q;

  // Saturating count of stalled cycles; only reset clears it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_count_q <= '0;
    end else if (stall && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: two instances (load latency 1 and 3) share
// stimulus and are compared each cycle against a time-stamp reference model.
module tb_hazard_scoreboard_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned NS = 2;
  localparam int unsigned NR = 32;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           issue_valid;
  logic           issue_mem_read;
  logic [AW-1:0]  issue_rd;
  logic [NS*AW-1:0] src_addr;
  logic [NS-1:0]  src_used;
  logic           mem_wait;
  logic           flush;
  logic [NS-1:0]  hz1, hz3;
  logic           st1, st3;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]    sc1, sc3;
`endif

  always #5 CLK = ~CLK;

  hazard_scoreboard_unit #(
    .REG_ADDR_W (AW),
    .NUM_SRC    (NS),
    .LOAD_LAT   (1)
  ) u_dut_lat1 (
    .CLK            (CLK),
    .RESET          (RESET),
    .issue_valid    (issue_valid),
    .issue_mem_read (issue_mem_read),
    .issue_rd       (issue_rd),
    .src_addr       (src_addr),
    .src_used       (src_used),
    .mem_wait       (mem_wait),
    .flush          (flush),
    .hazard_vec     (hz1),
    .stall          (st1)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_count    (sc1)
`endif
  );

  hazard_scoreboard_unit #(
    .REG_ADDR_W (AW),
    .NUM_SRC    (NS),
    .LOAD_LAT   (3)
  ) u_dut_lat3 (
    .CLK            (CLK),
    .RESET          (RESET),
    .issue_valid    (issue_valid),
    .issue_mem_read (issue_mem_read),
    .issue_rd       (issue_rd),
    .src_addr       (src_addr),
    .src_used       (src_used),
    .mem_wait       (mem_wait),
    .flush          (flush),
    .hazard_vec     (hz3),
    .stall          (st3)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_count    (sc3)
`endif
  );

  // Reference model: "effective time" advances on every edge without mem_wait;
  // a register is busy until effective time reaches its ready stamp.
  longint      eff     [2];
  longint      ready   [2][NR];
  longint      cnt_m   [2];
  int unsigned lat_m   [2] = '{1, 3};
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NS-1:0] model_hz(input int k);
    logic [NS-1:0] h;
    int            a;
    h = '0;
    for (int i = 0; i < int'(NS); i++) begin
      a = int'(src_addr[i*AW +: AW]);
      h[i] = src_used[i] && (a != 0) && (ready[k][a] > eff[k]);
    end
    return h;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      eff[k]   = 0;
      cnt_m[k] = 0;
      for (int r = 0; r < int'(NR); r++) ready[k][r] = 0;
    end
  endtask

  task automatic model_edge();
    logic s [2];
    for (int k = 0; k < 2; k++) s[k] = |model_hz(k);
    for (int k = 0; k < 2; k++) begin
      if (s[k] && cnt_m[k] < 64'hFFFF_FFFF) cnt_m[k]++;
      if (flush) begin
        for (int r = 0; r < int'(NR); r++) ready[k][r] = 0;
      end else begin
        if (!mem_wait) eff[k]++;
        if (issue_valid && issue_mem_read && !s[k] && issue_rd != '0)
          ready[k][issue_rd] = eff[k] + longint'(lat_m[k]);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val($sformatf("%s hz_lat1", tag), 32'(hz1), 32'(model_hz(0)));
    check_val($sformatf("%s stall_lat1", tag), 32'(st1), 32'(|model_hz(0)));
    check_val($sformatf("%s hz_lat3", tag), 32'(hz3), 32'(model_hz(1)));
    check_val($sformatf("%s stall_lat3", tag), 32'(st3), 32'(|model_hz(1)));
`ifdef HAZARD_PERF_CNT_EN
    check_val($sformatf("%s count_lat1", tag), sc1, 32'(cnt_m[0]));
    check_val($sformatf("%s count_lat3", tag), sc3, 32'(cnt_m[1]));
`endif
  endtask

  // Check mid-cycle, then advance one clock; leaves time at posedge+1.
  task automatic tick(input string tag);
    #3;
    check_outputs(tag);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    issue_valid    = 1'b0;
    issue_mem_read = 1'b0;
    issue_rd       = '0;
    src_addr       = '0;
    src_used       = '0;
    mem_wait       = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic issue_load(input int rd);
    set_idle();
    issue_valid    = 1'b1;
    issue_mem_read = 1'b1;
    issue_rd       = AW'(rd);
  endtask

  task automatic use_src(input int port, input int a);
    src_addr[port*AW +: AW] = AW'(a);
    src_used[port]          = 1'b1;
  endtask

  task automatic drain(input string tag);
    set_idle();
    repeat (4) tick(tag);
  endtask

  task automatic do_reset(input string tag);
    RESET = 1'b1;
    model_reset();
    #1;
    check_outputs($sformatf("%s in_reset", tag));
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    set_idle();
    RESET = 1'b1;
    model_reset();
    #2;
    check_val("reset stall_lat1", 32'(st1), 32'd0);
    check_val("reset hz_lat3", 32'(hz3), 32'd0);
    check_outputs("reset");
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Back-to-back load-use with latency 1: exactly one stall.
    issue_load(5);
    tick("ld_use.issue");
    set_idle(); use_src(0, 5);
    #1; check_val("ld_use.t1 stall_lat1", 32'(st1), 32'd1);
    tick("ld_use.t1");
    set_idle(); issue_valid = 1'b1; use_src(0, 5);
    #1; check_val("ld_use.t2 stall_lat1", 32'(st1), 32'd0);
    tick("ld_use.t2");
    drain("ld_use.drain");

    // Latency 3: consumer waits three cycles.
    issue_load(7);
    tick("lat3.issue");
    set_idle(); use_src(0, 7);
    for (int c = 0; c < 3; c++) begin
      #1; check_val($sformatf("lat3.wait%0d stall_lat3", c), 32'(st3), 32'd1);
      tick("lat3.wait");
    end
    #1; check_val("lat3.done stall_lat3", 32'(st3), 32'd0);
    tick("lat3.done");
    drain("lat3.drain");

    // x0 never tracked; an unused source never flags.
    issue_load(0);
    tick("x0.issue");
    set_idle(); use_src(0, 0);
    #1; check_val("x0.use stall_lat1", 32'(st1), 32'd0);
    tick("x0.use");
    issue_load(5);
    tick("unused.issue");
    set_idle(); use_src(0, 6); src_addr[AW +: AW] = AW'(5);
    #1; check_val("unused.src1 stall_lat3", 32'(st3), 32'd0);
    tick("unused.src1");
    drain("unused.drain");

    // mem_wait freezes the countdown: 4 frozen + 1 live stall cycles.
    issue_load(9);
    tick("memwait.issue");
    set_idle(); use_src(0, 9); mem_wait = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1; check_val($sformatf("memwait.hold%0d stall_lat1", c), 32'(st1), 32'd1);
      tick("memwait.hold");
    end
    mem_wait = 1'b0;
    #1; check_val("memwait.last stall_lat1", 32'(st1), 32'd1);
    tick("memwait.last");
    #1; check_val("memwait.free stall_lat1", 32'(st1), 32'd0);
    tick("memwait.free");
    drain("memwait.drain");

    // Flush clears a pending load and kills a coincident one.
    issue_load(3);
    tick("flush.ld3");
    issue_load(4); flush = 1'b1;
    tick("flush.edge");
    set_idle(); use_src(0, 3); use_src(1, 4);
    #1; check_val("flush.after stall_lat3", 32'(st3), 32'd0);
    check_val("flush.after stall_lat1", 32'(st1), 32'd0);
    tick("flush.after");
    drain("flush.drain");

    // Reset while x12 busy.
    issue_load(12);
    tick("rst.issue");
    set_idle(); use_src(0, 12);
    #1; check_val("rst.before stall_lat3", 32'(st3), 32'd1);
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    check_val("rst.async stall_lat3", 32'(st3), 32'd0);
    check_val("rst.async stall_lat1", 32'(st1), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check_val("rst.async count_lat3", sc3, 32'd0);
`endif
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    tick("rst.after");
    drain("rst.drain");

    // Randomized traffic over a small register window to force collisions.
    for (int n = 0; n < 3000; n++) begin
      issue_valid    = 1'($urandom_range(0, 1));
      issue_mem_read = ($urandom_range(0, 2) != 0);
      issue_rd       = AW'($urandom_range(0, 7));
      src_addr       = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      src_used       = NS'($urandom_range(0, 3));
      mem_wait       = ($urandom_range(0, 7) == 0);
      flush          = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) do_reset("rand.reset");
      else tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
